channel_sample_packer_buffer: RTL and testbench

//  Per-board capture stage feeding the DRAM address generator; one instance per RX board (8 total).

---
 rtl/channel_sample_packer_buffer_if.sv | 37 +++
 rtl/channel_sample_packer_buffer.sv | 167 ++++++++++++++++
 tb/tb_channel_sample_packer_buffer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/channel_sample_packer_buffer_if.sv
// Sample-in / word-out bundle for the channel sample packer buffer.
// TEST_PATTERN_EN adds the pattern_sel ramp-select input.
interface channel_sample_packer_buffer_if #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned WORD_W   = 256,
    parameter int unsigned TS_W     = 16
);
    logic [SAMPLE_W-1:0] rx_data;
    logic                rx_valid;
    logic                BRAM_rd_request;
    logic                BRAM_ready;
    logic [WORD_W-1:0]   BRAM_rd_data;
    logic                rd_data_valid;
    logic [TS_W-1:0]     burst_ts;
    logic                overflow;
`ifdef TEST_PATTERN_EN
    logic                pattern_sel;

    modport master (
        output rx_data, rx_valid, BRAM_rd_request, pattern_sel,
        input  BRAM_ready, BRAM_rd_data, rd_data_valid, burst_ts, overflow
    );
    modport slave (
        input  rx_data, rx_valid, BRAM_rd_request, pattern_sel,
        output BRAM_ready, BRAM_rd_data, rd_data_valid, burst_ts, overflow
    );
`else
    modport master (
        output rx_data, rx_valid, BRAM_rd_request,
        input  BRAM_ready, BRAM_rd_data, rd_data_valid, burst_ts, overflow
    );
    modport slave (
        input  rx_data, rx_valid, BRAM_rd_request,
        output BRAM_ready, BRAM_rd_data, rd_data_valid, burst_ts, overflow
    );
`endif
endinterface

// File: rtl/channel_sample_packer_buffer.sv
// Packs RX samples into wide words, buffers whole bursts in a circular BRAM, drops whole bursts
// when full. TEST_PATTERN_EN selects a sample-counter ramp as lane data via pattern_sel.
module channel_sample_packer_buffer #(
    parameter int unsigned SAMPLE_W     = 16,
    parameter int unsigned WORD_W       = 256,
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned DEPTH_BURSTS = 4,
    parameter int unsigned TS_W         = 16
) (
    input logic                          avalon_clk,
    input logic                          rst,
    channel_sample_packer_buffer_if.slave bus
);
    localparam int unsigned LANES    = WORD_W / SAMPLE_W;
    localparam int unsigned CAPACITY = DEPTH_BURSTS * BURST_LEN;
    localparam int unsigned LANE_W   = $clog2(LANES);
    localparam int unsigned WIDX_W   = $clog2(BURST_LEN);
    localparam int unsigned SLOT_W   = $clog2(DEPTH_BURSTS);
    localparam int unsigned ADDR_W   = SLOT_W + WIDX_W;
    localparam int unsigned CNT_W    = SLOT_W + 1;

    typedef enum logic [1:0] {StIdle, StFill, StDrop} state_e;

    state_e                      state_q, state_d;
    logic [LANE_W-1:0]           lane_q, lane_d;
    logic [WIDX_W-1:0]           widx_q, widx_d;
    logic [SLOT_W-1:0]           wr_slot_q, wr_slot_d;
    logic [SLOT_W-1:0]           rd_slot_q, rd_slot_d;
    logic [WIDX_W-1:0]           rd_widx_q, rd_widx_d;
    logic [CNT_W-1:0]            complete_q, complete_d;
    logic [TS_W-1:0]             sample_cnt_q, sample_cnt_d;
    logic                        overflow_q, overflow_d;
    logic                        ready_q, ready_d;
    logic                        rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0]           rd_data_q;
    logic [WORD_W-SAMPLE_W-1:0]  pack_q, pack_d;
    logic [TS_W-1:0]             ts_q [DEPTH_BURSTS];
    logic [TS_W-1:0]             ts_d [DEPTH_BURSTS];
    logic [WORD_W-1:0]           mem [CAPACITY];

    logic [SAMPLE_W-1:0] lane_data;
    logic                slot_free, fill_now, last_lane, last_word;
    logic                wr_en, rd_en, burst_done, burst_read;

`ifdef TEST_PATTERN_EN
    assign lane_data = bus.pattern_sel ? SAMPLE_W'(sample_cnt_q) : bus.rx_data;
`else
    assign lane_data = bus.rx_data;
`endif

    // In-progress bursts only exist in StFill, so at a burst boundary only completed slots count.
    assign slot_free = complete_q < CNT_W'(DEPTH_BURSTS);
    assign fill_now  = (state_q == StFill) || ((state_q == StIdle) && slot_free);
    assign last_lane = lane_q == LANE_W'(LANES - 1);
    assign last_word = widx_q == WIDX_W'(BURST_LEN - 1);
    assign rd_en     = bus.BRAM_rd_request && (complete_q != '0);

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        widx_d       = widx_q;
        wr_slot_d    = wr_slot_q;
        rd_slot_d    = rd_slot_q;
        rd_widx_d    = rd_widx_q;
        sample_cnt_d = sample_cnt_q;
        overflow_d   = overflow_q;
        pack_d       = pack_q;
        ts_d         = ts_q;
        wr_en        = 1'b0;
        burst_done   = 1'b0;
        burst_read   = 1'b0;
        rd_valid_d   = 1'b0;

        if (bus.rx_valid) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
            if (state_q == StIdle) begin
                if (slot_free) begin
                    ts_d[wr_slot_q] = sample_cnt_q;
                    state_d         = StFill;
                end else begin
                    overflow_d = 1'b1;
                    state_d    = StDrop;
                end
            end
            lane_d = lane_q + 1'b1;
            if (last_lane) widx_d = widx_q + 1'b1;
            if (fill_now) begin
                if (last_lane) begin
                    wr_en = 1'b1;
                end else begin
                    for (int k = 0; k < int'(LANES) - 1; k++) begin
                        if (lane_q == LANE_W'(k)) pack_d[k*SAMPLE_W +: SAMPLE_W] = lane_data;
                    end
                end
            end
            if (last_lane && last_word) begin
                state_d = StIdle;
                if (fill_now) begin
                    burst_done = 1'b1;
                    wr_slot_d  = wr_slot_q + 1'b1;
                end
            end
        end

        if (rd_en) begin
            rd_valid_d = 1'b1;
            rd_widx_d  = rd_widx_q + 1'b1;
            if (rd_widx_q == WIDX_W'(BURST_LEN - 1)) begin
                burst_read = 1'b1;
                rd_slot_d  = rd_slot_q + 1'b1;
            end
        end

        unique case ({burst_done, burst_read})
            2'b10:   complete_d = complete_q + 1'b1;
            2'b01:   complete_d = complete_q - 1'b1;
            default: complete_d = complete_q;
        endcase
        ready_d = complete_d != '0;
    end

    always_ff @(posedge avalon_clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            lane_q       <= '0;
            widx_q       <= '0;
            wr_slot_q    <= '0;
            rd_slot_q    <= '0;
            rd_widx_q    <= '0;
            complete_q   <= '0;
            sample_cnt_q <= '0;
            overflow_q   <= 1'b0;
            ready_q      <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            pack_q       <= '0;
            ts_q         <= '{default: '0};
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            widx_q       <= widx_d;
            wr_slot_q    <= wr_slot_d;
            rd_slot_q    <= rd_slot_d;
            rd_widx_q    <= rd_widx_d;
            complete_q   <= complete_d;
            sample_cnt_q <= sample_cnt_d;
            overflow_q   <= overflow_d;
            ready_q      <= ready_d;
            rd_valid_q   <= rd_valid_d;
            pack_q       <= pack_d;
            ts_q         <= ts_d;
            if (rd_en) rd_data_q <= mem[{rd_slot_q, rd_widx_q}];
        end
    end

    // Storage is not reset; cleared pointers make stale contents unreachable.
    always_ff @(posedge avalon_clk) begin
        if (rst && wr_en) mem[ADDR_W'({wr_slot_q, widx_q})] <= {lane_data, pack_q};
    end

    assign bus.BRAM_ready    = ready_q;
    assign bus.BRAM_rd_data  = rd_data_q;
    assign bus.rd_data_valid = rd_valid_q;
    assign bus.burst_ts      = ts_q[rd_slot_q];
    assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_channel_sample_packer_buffer.sv
// Directed bench for channel_sample_packer_buffer: packing, reads, drops, wrap and reset.
module tb_channel_sample_packer_buffer;
    logic avalon_clk = 1'b0;
    logic rst        = 1'b0;
    int   n_checks   = 0;
    int   n_fail     = 0;

    always #5 avalon_clk = ~avalon_clk;

    channel_sample_packer_buffer_if bus ();

    channel_sample_packer_buffer dut (
        .avalon_clk(avalon_clk),
        .rst       (rst),
        .bus       (bus)
    );

    task automatic tick();
        @(posedge avalon_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] exp_word(input int base, input int w);
        logic [255:0] r;
        for (int k = 0; k < 16; k++) r[k*16 +: 16] = 16'(base + 16 * w + k);
        return r;
    endfunction

    task automatic push(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 16'(base + i);
            tick();
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic read_words(input string tag, input int base, input int n);
        for (int w = 0; w < n; w++) begin
            bus.BRAM_rd_request = 1'b1;
            tick();
            check({tag, "_valid"}, 256'(bus.rd_data_valid), 256'(1));
            check({tag, "_data"}, bus.BRAM_rd_data, exp_word(base, w));
        end
        bus.BRAM_rd_request = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 256'(bus.BRAM_ready), 256'(0));
        check({tag, "_valid"}, 256'(bus.rd_data_valid), 256'(0));
        check({tag, "_data"}, bus.BRAM_rd_data, 256'(0));
        check({tag, "_ts"}, 256'(bus.burst_ts), 256'(0));
        check({tag, "_ovf"}, 256'(bus.overflow), 256'(0));
    endtask

    initial begin
        bus.rx_valid        = 1'b0;
        bus.rx_data         = '0;
        bus.BRAM_rd_request = 1'b0;
`ifdef TEST_PATTERN_EN
        bus.pattern_sel     = 1'b0;
`endif
        tick();
        do_reset();
        check_all_zero("reset");

        // One burst of 0..255, read back, then one request too many.
        push(0, 255);
        check("ready_before_last", 256'(bus.BRAM_ready), 256'(0));
        push(255, 1);
        check("ready_after_burst", 256'(bus.BRAM_ready), 256'(1));
        check("ts_first", 256'(bus.burst_ts), 256'(0));
        read_words("rd0", 0, 16);
        check("ready_after_drain", 256'(bus.BRAM_ready), 256'(0));
        bus.BRAM_rd_request = 1'b1;
        tick();
        check("extra_req_valid", 256'(bus.rd_data_valid), 256'(0));
        check("extra_req_hold", bus.BRAM_rd_data, exp_word(0, 15));
        bus.BRAM_rd_request = 1'b0;
        tick();
        check("idle_valid", 256'(bus.rd_data_valid), 256'(0));

        // Five bursts with no reads: the fifth is dropped.
        do_reset();
        for (int b = 0; b < 4; b++) push(256 * b, 256);
        check("full_ready", 256'(bus.BRAM_ready), 256'(1));
        check("full_no_ovf", 256'(bus.overflow), 256'(0));
        push(1024, 1);
        check("drop_ovf", 256'(bus.overflow), 256'(1));
        push(1025, 255);
        read_words("rd_b0", 0, 16);
        check("ts_after_b0", 256'(bus.burst_ts), 256'(256));
        push(16'h5000, 256);
        read_words("rd_b1", 256, 16);
        check("ts_b2", 256'(bus.burst_ts), 256'(512));
        read_words("rd_b2", 512, 16);
        check("ts_b3", 256'(bus.burst_ts), 256'(768));
        read_words("rd_b3", 768, 16);
        check("ts_wrapped", 256'(bus.burst_ts), 256'(1280));
        check("ovf_sticky", 256'(bus.overflow), 256'(1));

        // Reset in the middle of a read and a fill.
        read_words("rd_b6", 16'h5000, 5);
        push(16'h6000, 100);
        rst                 = 1'b0;
        bus.BRAM_rd_request = 1'b1;
        bus.rx_valid        = 1'b1;
        tick();
        check_all_zero("mid_reset");
        rst                 = 1'b1;
        bus.BRAM_rd_request = 1'b0;
        bus.rx_valid        = 1'b0;
        push(16'h7000, 256);
        check("post_reset_ready", 256'(bus.BRAM_ready), 256'(1));
        check("post_reset_ts", 256'(bus.burst_ts), 256'(0));
        read_words("rd_post", 16'h7000, 16);

        // Last read of burst 0 coincides with the final write of burst 1.
        do_reset();
        push(16'h1000, 256);
        for (int i = 0; i < 256; i++) begin
            bus.rx_valid        = 1'b1;
            bus.rx_data         = 16'(16'h2000 + i);
            bus.BRAM_rd_request = (i >= 240);
            tick();
            if (i >= 240) begin
                check("ovl_valid", 256'(bus.rd_data_valid), 256'(1));
                check("ovl_data", bus.BRAM_rd_data, exp_word(16'h1000, i - 240));
            end
        end
        bus.rx_valid        = 1'b0;
        bus.BRAM_rd_request = 1'b0;
        check("ovl_ready", 256'(bus.BRAM_ready), 256'(1));
        check("ovl_ts", 256'(bus.burst_ts), 256'(256));
        read_words("rd_b1_ovl", 16'h2000, 16);
        check("ovl_drained", 256'(bus.BRAM_ready), 256'(0));

`ifdef TEST_PATTERN_EN
        do_reset();
        bus.pattern_sel = 1'b1;
        push(16'hFFFF, 1);
        bus.rx_data = 16'hFFFF;
        for (int i = 1; i < 256; i++) begin
            bus.rx_valid = 1'b1;
            tick();
        end
        bus.rx_valid    = 1'b0;
        bus.pattern_sel = 1'b0;
        read_words("pattern", 0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
